// File: rtl/ahb_req_arbiter.sv
// ahb_req_arbiter: three requesters share one AHB-lite single-transfer
// path to an AHB-to-APB bridge, granted round-robin.
//
// Ports:
//   HCLK, HRESET          clock, async active-high reset
//   req/wr[2:0]           per-requester request and direction (1 = write)
//   addr0..2, wdata0..2   per-requester address and write data
//   gnt, done[2:0]        one-hot grant, one-hot one-cycle completion pulse
//   err, rdata            error flag and read data, valid with done
//   HADDR/HWDATA/HWRITE/HTRANS/HREADYin   AHB master side to the bridge
//   HREADYout/HRDATA/HRESP                AHB responses from the bridge
//
// Build option: define ARB_TIMEOUT_EN to add a wait-state watchdog that
// ends a transfer with err=1 after TO_CYC consecutive stalled cycles.
module ahb_req_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int TO_CYC = 16
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic [2:0]    req,
  input  logic [2:0]    wr,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic [DW-1:0] wdata2,
  output logic [2:0]    gnt,
  output logic [2:0]    done,
  output logic          err,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] HADDR,
  output logic [DW-1:0] HWDATA,
  output logic          HWRITE,
  output logic [1:0]    HTRANS,
  output logic          HREADYin,
  input  logic          HREADYout,
  input  logic [DW-1:0] HRDATA,
  input  logic [1:0]    HRESP
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  state_t        state;
  state_t        nxt;
  logic [1:0]    last;
  logic [1:0]    win;
  logic [1:0]    pick;
  logic          pick_v;
  logic [1:0]    cand;
  logic [DW-1:0] wbuf;
  logic          fin;
  logic          tmo;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYC + 1);

  logic [CW-1:0] cnt;

  // Fires on the TO_CYC-th consecutive stalled ADDR/DATA cycle.
  assign tmo = (state != IDLE) && !HREADYout &&
               (cnt == CW'(TO_CYC - 1));

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      cnt <= '0;
    end else if (state == IDLE || HREADYout || tmo) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  logic unused_to;

  assign unused_to = |TO_CYC;
  assign tmo       = 1'b0;
`endif

  assign fin      = (state == DATA) && HREADYout;
  assign HTRANS   = (state == ADDR) ? 2'b10 : 2'b00;
  assign HREADYin = 1'b1;

  // Search starts one past the last completed requester.
  always_comb begin
    pick_v = 1'b0;
    pick   = 2'd0;
    cand   = last;
    for (int i = 0; i < 3; i++) begin
      cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
      if (!pick_v && req[cand]) begin
        pick_v = 1'b1;
        pick   = cand;
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (pick_v) nxt = ADDR;
      ADDR: begin
        if (tmo) nxt = IDLE;
        else if (HREADYout) nxt = DATA;
      end
      DATA: if (fin || tmo) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      gnt    <= '0;
      done   <= '0;
      err    <= 1'b0;
      rdata  <= '0;
      HADDR  <= '0;
      HWDATA <= '0;
      HWRITE <= 1'b0;
      last   <= 2'd2;
      win    <= 2'd0;
      wbuf   <= '0;
    end else begin
      done <= '0;
      err  <= 1'b0;
      if (state == IDLE && pick_v) begin
        win    <= pick;
        gnt    <= 3'b001 << pick;
        HWRITE <= wr[pick];
        unique case (pick)
          2'd0: begin
            HADDR <= addr0;
            wbuf  <= wdata0;
          end
          2'd1: begin
            HADDR <= addr1;
            wbuf  <= wdata1;
          end
          default: begin
            HADDR <= addr2;
            wbuf  <= wdata2;
          end
        endcase
      end
      if (state == ADDR && HREADYout) begin
        HWDATA <= wbuf;
      end
      if (fin || tmo) begin
        done <= 3'b001 << win;
        err  <= tmo || (HRESP == 2'b01);
        gnt  <= '0;
        last <= win;
        if (fin && !HWRITE) begin
          rdata <= HRDATA;
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_req_arbiter.sv
// tb_ahb_req_arbiter: randomized transfers against a transaction-level
// round-robin model, plus directed reset, error and stall cases.
module tb_ahb_req_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          HCLK = 1'b0;
  logic          HRESET = 1'b0;
  logic [2:0]    req = '0;
  logic [2:0]    wr = '0;
  logic [AW-1:0] am [3];
  logic [DW-1:0] dm [3];
  logic [2:0]    gnt;
  logic [2:0]    done;
  logic          err;
  logic [DW-1:0] rdata;
  logic [AW-1:0] HADDR;
  logic [DW-1:0] HWDATA;
  logic          HWRITE;
  logic [1:0]    HTRANS;
  logic          HREADYin;
  logic          HREADYout = 1'b1;
  logic [DW-1:0] HRDATA = '0;
  logic [1:0]    HRESP = '0;

  int            nerr = 0;
  int            nchk = 0;
  int            mlast = 2;
  logic [DW-1:0] mrd = '0;

  always #5 HCLK = ~HCLK;

  ahb_req_arbiter #(
    .AW(AW),
    .DW(DW),
    .TO_CYC(TO)
  ) dut (
    .HCLK(HCLK),
    .HRESET(HRESET),
    .req(req),
    .wr(wr),
    .addr0(am[0]),
    .addr1(am[1]),
    .addr2(am[2]),
    .wdata0(dm[0]),
    .wdata1(dm[1]),
    .wdata2(dm[2]),
    .gnt(gnt),
    .done(done),
    .err(err),
    .rdata(rdata),
    .HADDR(HADDR),
    .HWDATA(HWDATA),
    .HWRITE(HWRITE),
    .HTRANS(HTRANS),
    .HREADYin(HREADYin),
    .HREADYout(HREADYout),
    .HRDATA(HRDATA),
    .HRESP(HRESP)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge HCLK);
    #1;
  endtask

  task automatic scr;
    for (int i = 0; i < 3; i++) begin
      am[i] = $urandom;
      dm[i] = $urandom;
    end
    wr = 3'($urandom);
  endtask

  function automatic int rr(input logic [2:0] rq);
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = (mlast + k) % 3;
      if (rq[c]) return c;
    end
    return -1;
  endfunction

  task automatic xfer(input logic [2:0] rq,
                      input logic [2:0] wv,
                      input int sa,
                      input int sd,
                      input logic [1:0] resp,
                      input bit sc,
                      input bit fix,
                      input logic [AW-1:0] fa,
                      input logic [DW-1:0] frd);
    int w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] rd;
    logic wb;
    scr();
    req = rq;
    wr = wv;
    if (fix) am[0] = fa;
    HREADYout = 1'($urandom);
    HRESP = 2'b00;
    w = rr(rq);
    a = '0;
    d = '0;
    wb = 1'b0;
    if (w >= 0) begin
      a = am[w];
      d = dm[w];
      wb = wv[w];
    end
    step;
    chk("idle_done", 64'(done), 64'd0);
    chk("idle_err", 64'(err), 64'd0);
    if (w < 0) begin
      chk("idle_gnt", 64'(gnt), 64'd0);
      chk("idle_trans", 64'(HTRANS), 64'd0);
      return;
    end
    chk("gnt", 64'(gnt), 64'(3'b001 << w));
    chk("addr_trans", 64'(HTRANS), 64'd2);
    chk("haddr", 64'(HADDR), 64'(a));
    chk("hwrite", 64'(HWRITE), 64'(wb));
    for (int i = 0; i < sa; i++) begin
      if (sc) begin
        scr();
        req = 3'($urandom);
      end
      HREADYout = 1'b0;
      HRESP = 2'($urandom);
      step;
      chk("astall_trans", 64'(HTRANS), 64'd2);
      chk("astall_haddr", 64'(HADDR), 64'(a));
      chk("astall_done", 64'(done), 64'd0);
    end
    if (sc) begin
      scr();
      req = 3'($urandom);
    end
    HREADYout = 1'b1;
    step;
    chk("data_trans", 64'(HTRANS), 64'd0);
    chk("hwdata", 64'(HWDATA), 64'(d));
    chk("data_gnt", 64'(gnt), 64'(3'b001 << w));
    chk("data_haddr", 64'(HADDR), 64'(a));
    chk("data_done", 64'(done), 64'd0);
    for (int i = 0; i < sd; i++) begin
      if (sc) scr();
      HREADYout = 1'b0;
      HRESP = 2'($urandom);
      step;
      chk("dstall_hwdata", 64'(HWDATA), 64'(d));
      chk("dstall_trans", 64'(HTRANS), 64'd0);
      chk("dstall_done", 64'(done), 64'd0);
      chk("dstall_err", 64'(err), 64'd0);
    end
    HREADYout = 1'b1;
    HRESP = resp;
    rd = fix ? frd : DW'($urandom);
    HRDATA = rd;
    step;
    chk("done", 64'(done), 64'(3'b001 << w));
    chk("err", 64'(err), 64'(resp == 2'b01));
    if (!wb) mrd = rd;
    chk("rdata", 64'(rdata), 64'(mrd));
    chk("end_gnt", 64'(gnt), 64'd0);
    chk("end_trans", 64'(HTRANS), 64'd0);
    mlast = w;
    HRESP = 2'b00;
  endtask

  task automatic chk_reset;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_trans", 64'(HTRANS), 64'd0);
    chk("rst_haddr", 64'(HADDR), 64'd0);
    chk("rst_hwdata", 64'(HWDATA), 64'd0);
    chk("rst_hwrite", 64'(HWRITE), 64'd0);
    chk("rst_hreadyin", 64'(HREADYin), 64'd1);
  endtask

  initial begin
    int w;
    logic [DW-1:0] rd;
    for (int i = 0; i < 3; i++) begin
      am[i] = '0;
      dm[i] = '0;
    end
    #2 HRESET = 1'b1;
    #1;
    chk_reset();
    step;
    step;
    chk_reset();
    HRESET = 1'b0;

    xfer(3'b001, 3'b000, 0, 0, 2'b00, 0, 1,
         32'h8000_0004, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) begin
      xfer(3'b111, 3'b111, 0, 0, 2'b00, 0, 0, '0, '0);
    end
    xfer(3'b010, 3'b010, 0, 3, 2'b00, 1, 0, '0, '0);
    xfer(3'b100, 3'b000, 1, 0, 2'b01, 1, 0, '0, '0);
    xfer(3'b100, 3'b000, 0, 0, 2'b00, 1, 0, '0, '0);

    for (int n = 0; n < 200; n++) begin
      logic [2:0] rq;
      rq = ($urandom_range(0, 5) == 0) ? 3'b000 : 3'($urandom);
      xfer(rq, 3'($urandom), $urandom_range(0, 3),
           $urandom_range(0, 3), 2'($urandom), 1, 0, '0, '0);
    end

    req = 3'b100;
    wr = 3'b000;
    HREADYout = 1'b1;
    w = rr(req);
    step;
    chk("rst_mid_gnt", 64'(gnt), 64'(3'b001 << w));
    req = 3'b000;
    step;
    chk("rst_mid_trans", 64'(HTRANS), 64'd0);
    HREADYout = 1'b0;
    #2 HRESET = 1'b1;
    #1;
    chk_reset();
    HREADYout = 1'b1;
    step;
    chk("rst_hold_done", 64'(done), 64'd0);
    HRESET = 1'b0;
    mlast = 2;
    mrd = '0;
    step;
    chk("rst_after_done", 64'(done), 64'd0);
    xfer(3'b111, 3'b000, 0, 0, 2'b00, 0, 0, '0, '0);

    req = 3'b001;
    wr = 3'b000;
    HREADYout = 1'b1;
    w = rr(req);
    step;
    chk("stk_gnt", 64'(gnt), 64'(3'b001 << w));
    req = 3'b000;
    step;
    HREADYout = 1'b0;
`ifdef ARB_TIMEOUT_EN
    for (int i = 1; i < TO; i++) begin
      step;
      chk("to_wait_done", 64'(done), 64'd0);
    end
    step;
    chk("to_done", 64'(done), 64'(3'b001 << w));
    chk("to_err", 64'(err), 64'd1);
    chk("to_gnt", 64'(gnt), 64'd0);
    chk("to_trans", 64'(HTRANS), 64'd0);
    chk("to_rdata", 64'(rdata), 64'(mrd));
    mlast = w;
`else
    for (int i = 0; i < TO + 4; i++) begin
      step;
      chk("stk_done", 64'(done), 64'd0);
      chk("stk_gnt_hold", 64'(gnt), 64'(3'b001 << w));
    end
    rd = $urandom;
    HRDATA = rd;
    HRESP = 2'b00;
    HREADYout = 1'b1;
    step;
    chk("stk_end_done", 64'(done), 64'(3'b001 << w));
    mrd = rd;
    chk("stk_rdata", 64'(rdata), 64'(mrd));
    mlast = w;
`endif
    xfer(3'b111, 3'b101, 0, 0, 2'b00, 0, 0, '0, '0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ahb_req_arbiter.md
AHB_REQ_ARBITER -- requirements
Module: ahb_req_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, meaning address width.
REQ-002 SHALL have parameter DW, default 32, meaning data width.
REQ-003 SHALL have parameter TO_CYC, default 16, meaning wait-state limit in cycles (used only under REQ-031).
REQ-004 Ports, one per line (name, direction, width, meaning):
- HCLK  in  1  single clock; all state changes on the rising edge.
- HRESET  in  1  reset; asynchronous, active-high.
- req  in  3  per-requester transfer request.
- wr  in  3  per-requester direction; 1 = write.
- addr0/addr1/addr2  in  AW  per-requester address.
- wdata0/wdata1/wdata2  in  DW  per-requester write data.
- gnt  out  3  one-hot grant.
- done  out  3  one-hot, one-cycle completion pulse.
- err  out  1  error flag, valid with done.
- rdata  out  DW  read data, valid with done.
- HADDR  out  AW  AHB address to the bridge.
- HWDATA  out  DW  AHB write data.
- HWRITE  out  1  AHB direction.
- HTRANS  out  2  AHB transfer type.
- HREADYin  out  1  ready into the bridge.
- HREADYout  in  1  ready from the bridge.
- HRDATA  in  DW  AHB read data.
- HRESP  in  2  AHB response; 2'b01 = ERROR.

Function
REQ-005 SHALL share one AHB-lite single-transfer path to the AHB-to-APB bridge among 3 requesters.
REQ-006 FSM states SHALL be IDLE, ADDR and DATA.
REQ-007 IDLE: if any req bit is high, SHALL pick a winner round-robin, set gnt one-hot and latch wr/addr/wdata, then go to ADDR next cycle.
REQ-008 Round-robin search SHALL start at (last+1) mod 3, where last is the most recently completed requester; last resets to 2, so requester 0 has first priority.
REQ-009 ADDR: SHALL drive HTRANS=2'b10 (NONSEQ), HADDR and HWRITE from the latched values; SHALL go to DATA on a cycle with HREADYout=1, otherwise hold ADDR.
REQ-010 DATA: SHALL drive HTRANS=2'b00 and HWDATA from the latched wdata; SHALL wait for HREADYout=1.
REQ-011 On DATA with HREADYout=1: SHALL pulse done[winner] for 1 cycle, capture HRDATA into rdata (reads only; writes leave rdata unchanged), set err=(HRESP==2'b01), clear gnt, update last, and return to IDLE.
REQ-012 Latency with zero wait states: req sampled in IDLE at cycle N, gnt visible at N+1, ADDR phase at N+1, DATA phase at N+2, done at N+3.
REQ-013 HREADYin SHALL be driven 1 in every state.
REQ-014 Changes on req, addr, wr or wdata after grant SHALL NOT affect the transfer in flight; dropping the granted req mid-transfer SHALL NOT abort it.
REQ-015 In the same cycle done pulses, the FSM SHALL NOT grant; IDLE lasts at least 1 cycle between transfers.
REQ-016 err SHALL be 0 whenever done is 0.
REQ-017 Outside ADDR, HADDR and HWRITE SHALL hold their last values.

Reset
REQ-018 On HRESET=1, regardless of state and including mid-transfer, SHALL immediately force: state=IDLE, gnt=0, done=0, err=0, rdata=0, HTRANS=2'b00, HADDR=0, HWDATA=0, HWRITE=0, HREADYin=1, last=2, timeout counter=0.
REQ-019 No done pulse SHALL be issued for a transfer aborted by reset.

Configuration
REQ-030 Macro ARB_TIMEOUT_EN SHALL gate the wait-state watchdog.
REQ-031 With ARB_TIMEOUT_EN defined: a counter SHALL count consecutive ADDR/DATA cycles with HREADYout=0; when it reaches TO_CYC, the FSM SHALL pulse done[winner] with err=1, set HTRANS=2'b00 and return to IDLE. The counter SHALL clear on any HREADYout=1 cycle and on entry to IDLE.
REQ-032 Without ARB_TIMEOUT_EN: no counter SHALL exist, and the FSM SHALL wait indefinitely on HREADYout.

Verification
REQ-040 Reset, then req=3'b001, wr=0, addr0=32'h8000_0004, HRDATA=32'hDEAD_BEEF, zero wait states -> gnt=001 at N+1, done=001 at N+3 with rdata=32'hDEAD_BEEF and err=0.
REQ-041 req=3'b111 held continuously, all writes -> completion order 0,1,2,0, with HADDR matching addr0/1/2 respectively.
REQ-042 Write from requester 1 with HREADYout low for 3 cycles in DATA -> HWDATA=wdata1 stable throughout, done=010 exactly once after HREADYout rises.
REQ-043 HRESP=2'b01 with HREADYout=1 in DATA -> done pulse with err=1; next transfer completes with err=0.
REQ-044 HRESET asserted during DATA -> gnt=0 and HTRANS=00 immediately, no done pulse; after release, requester 0 wins first.
REQ-045 ARB_TIMEOUT_EN defined, TO_CYC=16, HREADYout stuck at 0 -> done with err=1 after 16 stalled cycles; build without the macro -> FSM remains in DATA.
